// File: rtl/conv_scale_pkg.sv
// rtl/conv_scale_pkg.sv - shared defaults and types for the conv scale bank
package conv_scale_pkg;

  localparam int SCALE_WIDTH_DEF = 24;
  localparam int NUM_CH_DEF      = 16;

  // Read-side sequencer states
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  typedef logic [SCALE_WIDTH_DEF-1:0] scale_word_t;

endpackage

// File: rtl/conv_scale_bank_if.sv
// rtl/conv_scale_bank_if.sv - load port and scale stream bundle for conv_scale_bank
interface conv_scale_bank_if
  import conv_scale_pkg::*;
#(
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int NUM_CH      = NUM_CH_DEF
) ();

  localparam int CH_W = $clog2(NUM_CH);

  logic                   load_valid;
  logic [SCALE_WIDTH-1:0] load_data;
  logic                   load_ready;
  logic                   load_done;
  logic                   rd_start;
  logic                   rd_ready;
  logic [SCALE_WIDTH-1:0] scale;
  logic [CH_W-1:0]        scale_ch;
  logic                   scale_valid;
  logic                   scale_last;
  logic                   bank_full;

  // Parameter loader / requant consumer side
  modport master (
    output load_valid, load_data, rd_start, rd_ready,
    input  load_ready, load_done, scale, scale_ch, scale_valid, scale_last, bank_full
  );

  // Scale bank side
  modport slave (
    input  load_valid, load_data, rd_start, rd_ready,
    output load_ready, load_done, scale, scale_ch, scale_valid, scale_last, bank_full
  );

endinterface

// File: rtl/conv_scale_mem.sv
// rtl/conv_scale_mem.sv - NUM_CH x SCALE_WIDTH scale storage, sync write, registered read
module conv_scale_mem
  import conv_scale_pkg::*;
#(
  parameter  int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter  int NUM_CH      = NUM_CH_DEF,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [CH_W-1:0]        wr_addr,
  input  logic [SCALE_WIDTH-1:0] wr_data,
  input  logic                   re,
  input  logic [CH_W-1:0]        rd_addr,
  output logic [SCALE_WIDTH-1:0] rd_data
);

  logic [SCALE_WIDTH-1:0] mem [NUM_CH];

  // Storage array has no reset; contents are only meaningful after a full load
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the scale output, so it holds whenever re is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_scale_bank.sv
// rtl/conv_scale_bank.sv - per-channel requant scale bank; CONV_SCALE_DOUBLE_BUF_EN selects two banks
module conv_scale_bank
  import conv_scale_pkg::*;
#(
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int NUM_CH      = NUM_CH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  conv_scale_bank_if.slave bus
);

  localparam int              CH_W    = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  rd_state_e              state_q, state_d;
  logic [CH_W-1:0]        ld_ptr;
  logic [CH_W-1:0]        rd_ch;
  logic [CH_W-1:0]        rd_addr;
  logic                   rd_en;
  logic                   start_go;
  logic                   load_done_q;
  logic                   bank_full_q;
  logic                   load_acc;
  logic                   load_wrap;
  logic                   out_acc;
  logic                   last_acc;
  logic                   start_block;
  logic                   set_full;
  logic                   clr_full;
  logic                   load_ready_int;
  logic [SCALE_WIDTH-1:0] scale_int;

  assign load_acc  = bus.load_valid && load_ready_int;
  assign load_wrap = load_acc && (ld_ptr == LAST_CH);
  assign out_acc   = (state_q == STREAM) && bus.rd_ready;
  assign last_acc  = out_acc && (rd_ch == LAST_CH);

  // Read sequencer: start condition, next state and read-port address
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = rd_ch + CH_W'(1);
    case (state_q)
      IDLE: begin
        if (bus.rd_start && bank_full_q && !start_block) begin
          start_go = 1'b1;
          rd_en    = 1'b1;
          rd_addr  = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (out_acc) begin
          if (rd_ch == LAST_CH) begin
            state_d = IDLE;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and channel index of the word currently presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_ch   <= '0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        rd_ch <= '0;
      end else if (out_acc && !last_acc) begin
        rd_ch <= rd_ch + CH_W'(1);
      end
    end
  end

  // Load pointer, completion pulse and full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ptr      <= '0;
      load_done_q <= 1'b0;
      bank_full_q <= 1'b0;
    end else begin
      load_done_q <= load_wrap;
      if (load_acc) begin
        ld_ptr <= load_wrap ? '0 : ld_ptr + CH_W'(1);
      end
      if (set_full) begin
        bank_full_q <= 1'b1;
      end else if (clr_full) begin
        bank_full_q <= 1'b0;
      end
    end
  end

`ifdef CONV_SCALE_DOUBLE_BUF_EN
  logic                   act_q;
  logic                   swap_pending_q;
  logic                   swap_now;
  logic [SCALE_WIDTH-1:0] rd_data0;
  logic [SCALE_WIDTH-1:0] rd_data1;

  // A finished shadow set goes live at once in IDLE, otherwise when the stream ends
  assign swap_now       = (load_wrap && ((state_q == IDLE) || last_acc))
                        || (last_acc && swap_pending_q);
  assign start_block    = load_wrap;
  assign set_full       = swap_now;
  assign clr_full       = 1'b0;
  assign load_ready_int = !swap_pending_q;
  assign scale_int      = act_q ? rd_data1 : rd_data0;

  // Active-bank select and deferred swap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q          <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      if (swap_now) begin
        act_q <= ~act_q;
      end
      if (swap_now) begin
        swap_pending_q <= 1'b0;
      end else if (load_wrap) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  conv_scale_mem #(.SCALE_WIDTH(SCALE_WIDTH), .NUM_CH(NUM_CH)) u_mem_bank0 (
    .clk(clk), .rst(rst),
    .we(load_acc && act_q), .wr_addr(ld_ptr), .wr_data(bus.load_data),
    .re(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  conv_scale_mem #(.SCALE_WIDTH(SCALE_WIDTH), .NUM_CH(NUM_CH)) u_mem_bank1 (
    .clk(clk), .rst(rst),
    .we(load_acc && !act_q), .wr_addr(ld_ptr), .wr_data(bus.load_data),
    .re(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1)
  );
`else
  // One bank: loads only in IDLE, and the first word of a new set invalidates it
  assign start_block    = load_acc;
  assign set_full       = load_wrap;
  assign clr_full       = load_acc && (ld_ptr == '0);
  assign load_ready_int = (state_q == IDLE);

  conv_scale_mem #(.SCALE_WIDTH(SCALE_WIDTH), .NUM_CH(NUM_CH)) u_mem_bank (
    .clk(clk), .rst(rst),
    .we(load_acc), .wr_addr(ld_ptr), .wr_data(bus.load_data),
    .re(rd_en), .rd_addr(rd_addr), .rd_data(scale_int)
  );
`endif

  assign bus.load_ready  = load_ready_int;
  assign bus.load_done   = load_done_q;
  assign bus.bank_full   = bank_full_q;
  assign bus.scale       = scale_int;
  assign bus.scale_ch    = rd_ch;
  assign bus.scale_valid = (state_q == STREAM);
  assign bus.scale_last  = (state_q == STREAM) && (rd_ch == LAST_CH);

endmodule

// File: tb/tb_conv_scale_bank.sv
// tb/tb_conv_scale_bank.sv - scoreboard bench for conv_scale_bank; honours CONV_SCALE_DOUBLE_BUF_EN
module tb_conv_scale_bank;
  import conv_scale_pkg::*;

  localparam int NCH = 4;
  localparam int SW  = 24;

  typedef struct packed {
    scale_word_t d;
    logic [1:0]  ch;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  scale_word_t set_a [NCH] = '{24'h000101, 24'h000202, 24'h000303, 24'h000404};
  scale_word_t set_b [NCH] = '{24'h0000B0, 24'h0000B1, 24'h0000B2, 24'h0000B3};
  scale_word_t set_c [NCH] = '{24'h0C0001, 24'h0C0002, 24'h0C0003, 24'h0C0004};
  scale_word_t set_d [NCH] = '{24'h0D1111, 24'h0D2222, 24'h0D3333, 24'h0D4444};
  scale_word_t cur   [NCH];

  conv_scale_bank_if #(.SCALE_WIDTH(SW), .NUM_CH(NCH)) bus ();

  conv_scale_bank #(.SCALE_WIDTH(SW), .NUM_CH(NCH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_scale"},       32'(bus.scale),       0);
    chk({pfx, "_scale_ch"},    32'(bus.scale_ch),    0);
    chk({pfx, "_scale_valid"}, 32'(bus.scale_valid), 0);
    chk({pfx, "_scale_last"},  32'(bus.scale_last),  0);
    chk({pfx, "_load_ready"},  32'(bus.load_ready),  1);
    chk({pfx, "_load_done"},   32'(bus.load_done),   0);
    chk({pfx, "_bank_full"},   32'(bus.bank_full),   0);
  endtask

  task automatic load_set(input scale_word_t w [NCH]);
    for (int i = 0; i < NCH; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = w[i];
      step();
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
  endtask

  task automatic start_stream(input scale_word_t w [NCH]);
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      e.d    = w[i];
      e.ch   = 2'(i);
      e.last = (i == NCH - 1);
      exp_q.push_back(e);
    end
    pulse_start();
  endtask

  task automatic drain(input string name, input bit toggle);
    int k = 0;
    while ((exp_q.size() != 0 || bus.scale_valid) && k < 200) begin
      bus.rd_ready = toggle ? (k % 3 == 0) : 1'b1;
      step();
      k++;
    end
    bus.rd_ready = 1'b1;
    chk({name, "_pending_words"}, 32'(exp_q.size()), 0);
    chk({name, "_valid_after"},   32'(bus.scale_valid), 0);
  endtask

  // Monitor: every presented word is compared with the scoreboard head; popped on accept
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.scale_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=ch%0d/0x%0h required=no output", bus.scale_ch, bus.scale);
        end else begin
          e = exp_q[0];
          chk(bus.rd_ready ? "scale"      : "scale_hold",      32'(bus.scale),      32'(e.d));
          chk(bus.rd_ready ? "scale_ch"   : "scale_ch_hold",   32'(bus.scale_ch),   32'(e.ch));
          chk(bus.rd_ready ? "scale_last" : "scale_last_hold", 32'(bus.scale_last), 32'(e.last));
          if (bus.rd_ready) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.rd_start   = 1'b0;
    bus.rd_ready   = 1'b1;
    rst            = 1'b1;
    repeat (3) step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // rd_start with nothing loaded
    pulse_start();
    chk("noload_valid",      32'(bus.scale_valid), 0);
    chk("noload_bank_full",  32'(bus.bank_full),   0);
    chk("noload_load_ready", 32'(bus.load_ready),  1);

    // Full load, then full-throughput stream
    load_set(set_a);
    chk("load_done_pulse", 32'(bus.load_done), 1);
    chk("bank_full_set",   32'(bus.bank_full), 1);
    step();
    chk("load_done_clear", 32'(bus.load_done), 0);
    start_stream(set_a);
    for (int i = 0; i < NCH; i++) begin
      chk("stream_valid_run", 32'(bus.scale_valid), 1);
      step();
    end
    chk("stream_valid_end", 32'(bus.scale_valid), 0);
    chk("stream_words_left", 32'(exp_q.size()), 0);

    // Backpressure 1,0,0,1,...
    start_stream(set_a);
    drain("toggle", 1'b1);

    // rd_start while streaming must not restart
    start_stream(set_a);
    step();
    pulse_start();
    drain("midstart", 1'b0);
    chk("replay_bank_full", 32'(bus.bank_full), 1);

`ifdef CONV_SCALE_DOUBLE_BUF_EN
    // Stream A while loading B into the shadow bank
    bus.rd_ready = 1'b0;
    start_stream(set_a);
    for (int i = 0; i < NCH; i++) begin
      chk("dbuf_load_ready_open", 32'(bus.load_ready), 1);
      bus.load_valid = 1'b1;
      bus.load_data  = set_b[i];
      step();
    end
    bus.load_valid = 1'b0;
    chk("dbuf_load_done",      32'(bus.load_done),  1);
    chk("dbuf_pending_ready",  32'(bus.load_ready), 0);
    chk("dbuf_bank_full",      32'(bus.bank_full),  1);
    begin
      int k = 0;
      while (bus.scale_valid && k < 50) begin
        bus.rd_ready = 1'b1;
        chk("dbuf_ready_low_in_stream", 32'(bus.load_ready), 0);
        step();
        k++;
      end
    end
    chk("dbuf_ready_after_swap", 32'(bus.load_ready),  1);
    chk("dbuf_a_words_left",     32'(exp_q.size()),    0);
    start_stream(set_b);
    drain("dbuf_set_b", 1'b0);
    cur = set_b;
`else
    // Loads are refused while streaming and must not corrupt the set
    bus.rd_ready = 1'b0;
    start_stream(set_a);
    bus.load_valid = 1'b1;
    bus.load_data  = 24'hDEAD00;
    chk("stream_load_ready", 32'(bus.load_ready), 0);
    repeat (3) step();
    chk("stream_load_ready_held", 32'(bus.load_ready), 0);
    bus.load_valid = 1'b0;
    drain("blocked_load", 1'b0);
    start_stream(set_a);
    drain("replay_after_blocked", 1'b0);

    // Load accept and rd_start together: load wins
    bus.load_valid = 1'b1;
    bus.load_data  = set_d[0];
    bus.rd_start   = 1'b1;
    step();
    bus.rd_start   = 1'b0;
    bus.load_valid = 1'b0;
    chk("simul_valid",     32'(bus.scale_valid), 0);
    chk("simul_bank_full", 32'(bus.bank_full),   0);

    // Partial load blocks rd_start
    bus.load_valid = 1'b1;
    bus.load_data  = set_d[1];
    step();
    bus.load_valid = 1'b0;
    pulse_start();
    chk("partial_valid",     32'(bus.scale_valid), 0);
    chk("partial_bank_full", 32'(bus.bank_full),   0);
    for (int i = 2; i < NCH; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = set_d[i];
      step();
    end
    bus.load_valid = 1'b0;
    chk("completed_bank_full", 32'(bus.bank_full), 1);
    start_stream(set_d);
    drain("set_d", 1'b0);
    cur = set_d;
`endif

    // Asynchronous reset at ch2 of a stream
    bus.rd_ready = 1'b1;
    start_stream(cur);
    step();
    step();
    chk("pre_rst_ch", 32'(bus.scale_ch), 2);
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    pulse_start();
    chk("post_rst_valid",     32'(bus.scale_valid), 0);
    chk("post_rst_bank_full", 32'(bus.bank_full),   0);
    load_set(set_c);
    chk("reload_bank_full", 32'(bus.bank_full), 1);
    start_stream(set_c);
    drain("reload", 1'b0);

    step();
    chk("final_words_left", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
